// File: rtl/ssm2603_i2c_arbiter_pkg.sv
// Shared definitions for the SSM2603 I2C write arbiter: FSM encoding, codec register map
// and the default transaction timeout.
package ssm2603_i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    StatOk  = 1'b0,
    StatErr = 1'b1
  } arb_status_e;

  localparam logic [15:0] DefTimeoutCyc = 16'd4096;

  // SSM2603 register addresses (7-bit word addresses)
  localparam logic [6:0] RegLeftAdcVol  = 7'h00;
  localparam logic [6:0] RegRightAdcVol = 7'h01;
  localparam logic [6:0] RegLeftDacVol  = 7'h02;
  localparam logic [6:0] RegRightDacVol = 7'h03;
  localparam logic [6:0] RegAnalogPath  = 7'h04;
  localparam logic [6:0] RegDigitalPath = 7'h05;
  localparam logic [6:0] RegPowerMgmt   = 7'h06;
  localparam logic [6:0] RegDigitalIf   = 7'h07;
  localparam logic [6:0] RegSampleRate  = 7'h08;
  localparam logic [6:0] RegActive      = 7'h09;
  localparam logic [6:0] RegR10         = 7'h0A;
  localparam logic [6:0] RegR11         = 7'h0B;
  localparam logic [6:0] RegR12         = 7'h0C;
  localparam logic [6:0] RegR13         = 7'h0D;
  localparam logic [6:0] RegR14         = 7'h0E;
  localparam logic [6:0] RegSwReset     = 7'h0F;

  // SSM2603 frames carry data bit 8 in the LSB of the word-address byte
  function automatic logic [7:0] pack_word_addr(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data[8]};
  endfunction

endpackage

// File: rtl/ssm2603_i2c_arbiter.sv
// Round-robin arbiter between the init sequencer and runtime control for a single i2c_dri,
// with one transaction in flight and a completion timeout.
module ssm2603_i2c_arbiter
  import ssm2603_i2c_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0_valid,
  input  logic [6:0] i_req0_addr,
  input  logic [8:0] i_req0_data,
  output logic       o_req0_done,
  output logic       o_req0_err,
  input  logic       i_req1_valid,
  input  logic [6:0] i_req1_addr,
  input  logic [8:0] i_req1_data,
  output logic       o_req1_done,
  output logic       o_req1_err,
  output logic       o_i2c_exec,
  output logic [7:0] o_i2c_addr,
  output logic [7:0] o_i2c_data_w,
  input  logic       i_i2c_done,
  output logic       o_busy,
  output logic       o_owner
);

  arb_state_e  r_state, w_state_d;
  arb_status_e r_status, w_status_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic        r_last, w_last_d;
  logic        r_owner, w_owner_d;
  logic [7:0]  r_addr, w_addr_d;
  logic [7:0]  r_data, w_data_d;

  logic w_any;
  logic w_grant;

  assign w_any   = i_req0_valid | i_req1_valid;
  // On a tie the requester not served last wins; otherwise the lone requester wins
  assign w_grant = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_status <= StatOk;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_status <= w_status_d;
      r_cnt    <= w_cnt_d;
      r_last   <= w_last_d;
      r_owner  <= w_owner_d;
      r_addr   <= w_addr_d;
      r_data   <= w_data_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_status_d = r_status;
    w_cnt_d    = r_cnt;
    w_last_d   = r_last;
    w_owner_d  = r_owner;
    w_addr_d   = r_addr;
    w_data_d   = r_data;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_owner_d = w_grant;
          if (w_grant) begin
            w_addr_d = pack_word_addr(i_req1_addr, i_req1_data);
            w_data_d = i_req1_data[7:0];
          end else begin
            w_addr_d = pack_word_addr(i_req0_addr, i_req0_data);
            w_data_d = i_req0_data[7:0];
          end
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        // A completion arriving on the last allowed cycle still counts as success
        if (i_i2c_done) begin
          w_status_d = StatOk;
          w_state_d  = StResp;
        end else if (r_cnt == TIMEOUT_CYC - 16'd1) begin
          w_status_d = StatErr;
          w_state_d  = StResp;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StResp: begin
        w_last_d  = r_owner;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_i2c_exec   = (r_state == StIssue);
    o_busy       = (r_state != StIdle);
    o_owner      = r_owner;
    o_i2c_addr   = r_addr;
    o_i2c_data_w = r_data;
    o_req0_done  = (r_state == StResp) && (r_status == StatOk)  && !r_owner;
    o_req0_err   = (r_state == StResp) && (r_status == StatErr) && !r_owner;
    o_req1_done  = (r_state == StResp) && (r_status == StatOk)  && r_owner;
    o_req1_err   = (r_state == StResp) && (r_status == StatErr) && r_owner;
  end

endmodule

// File: tb/tb_ssm2603_i2c_arbiter.sv
// Scoreboard bench for ssm2603_i2c_arbiter: stimulus queues expected i2c frames and completions,
// a negedge monitor pops and compares them whenever the DUT issues exec or a done/err pulse.
module tb_ssm2603_i2c_arbiter;

  localparam logic [15:0] TimeoutCyc = 16'd16;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [8:0] req0_data, req1_data;
  logic       req0_done, req0_err, req1_done, req1_err;
  logic       i2c_exec, i2c_done, busy, owner;
  logic [7:0] i2c_addr, i2c_data_w;

  ssm2603_i2c_arbiter #(.TIMEOUT_CYC(TimeoutCyc)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .i_req0_addr  (req0_addr),
    .i_req0_data  (req0_data),
    .o_req0_done  (req0_done),
    .o_req0_err   (req0_err),
    .i_req1_valid (req1_valid),
    .i_req1_addr  (req1_addr),
    .i_req1_data  (req1_data),
    .o_req1_done  (req1_done),
    .o_req1_err   (req1_err),
    .o_i2c_exec   (i2c_exec),
    .o_i2c_addr   (i2c_addr),
    .o_i2c_data_w (i2c_data_w),
    .i_i2c_done   (i2c_done),
    .o_busy       (busy),
    .o_owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       who;
    logic       err;
  } exp_t;

  exp_t exec_q[$];
  exp_t resp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic expect_txn(input logic who, input logic [7:0] a, input logic [7:0] d,
                            input logic err);
    exp_t e;
    e = '{a: a, d: d, who: who, err: err};
    exec_q.push_back(e);
    resp_q.push_back(e);
  endtask

  // Monitor: every exec and every done/err pulse must match the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (i2c_exec) begin
        if (exec_q.size() == 0) fail("unexpected_exec");
        else begin
          mon_e = exec_q.pop_front();
          chk("exec_addr", 32'(i2c_addr), 32'(mon_e.a));
          chk("exec_data", 32'(i2c_data_w), 32'(mon_e.d));
        end
      end
      if (req0_done | req0_err | req1_done | req1_err) begin
        chk("done_err_exclusive", 32'((req0_done | req1_done) & (req0_err | req1_err)), 0);
        chk("single_requester", 32'((req0_done | req0_err) & (req1_done | req1_err)), 0);
        if (resp_q.size() == 0) fail("unexpected_pulse");
        else begin
          mon_e = resp_q.pop_front();
          chk("resp_who", 32'(req1_done | req1_err), 32'(mon_e.who));
          chk("resp_err", 32'(req0_err | req1_err), 32'(mon_e.err));
          chk("resp_owner", 32'(owner), 32'(mon_e.who));
          chk("resp_addr_held", 32'(i2c_addr), 32'(mon_e.a));
          chk("resp_data_held", 32'(i2c_data_w), 32'(mon_e.d));
        end
      end
    end
  end

  task automatic wait_exec();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i2c_exec) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("exec_wait_timeout");
  endtask

  task automatic pulse_done_after(input int n);
    repeat (n) @(posedge clk);
    #1 i2c_done = 1'b1;
    @(posedge clk);
    #1 i2c_done = 1'b0;
  endtask

  task automatic one_shot(input logic who, input logic [6:0] a, input logic [8:0] d);
    @(posedge clk);
    #1;
    if (who) begin
      req1_valid = 1'b1; req1_addr = a; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_addr = a; req0_data = d;
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i2c_done = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exec_q.delete();
    resp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    i2c_done = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_exec", 32'(i2c_exec), 0);
    chk("rst_addr", 32'(i2c_addr), 0);
    chk("rst_data", 32'(i2c_data_w), 0);
    chk("rst_pulses", 32'({req0_done, req0_err, req1_done, req1_err}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic write: exec one cycle after valid is sampled, done one cycle after i2c_done
    expect_txn(1'b0, 8'h08, 8'h12, 1'b0);
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_addr = 7'h04; req0_data = 9'h012;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("exec_latency", 32'(i2c_exec), 1);
    pulse_done_after(10);
    @(negedge clk);
    chk("done_latency", 32'(req0_done), 1);
    @(negedge clk);
    chk("idle_after_resp", 32'(busy), 0);

    // Round-robin with both requesters holding valid: 0,1,0,1
    do_reset();
    expect_txn(1'b0, 8'h0C, 8'h00, 1'b0);
    expect_txn(1'b1, 8'h12, 8'h01, 1'b0);
    expect_txn(1'b0, 8'h0C, 8'h00, 1'b0);
    expect_txn(1'b1, 8'h12, 8'h01, 1'b0);
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_addr = 7'h06; req0_data = 9'h000;
    req1_valid = 1'b1; req1_addr = 7'h09; req1_data = 9'h001;
    for (int i = 0; i < 4; i++) begin
      wait_exec();
      if (i == 2) req0_valid = 1'b0;
      if (i == 3) req1_valid = 1'b0;
      pulse_done_after(3);
      @(negedge clk);
      chk("rr_owner", 32'(owner), 32'(i % 2));
    end

    // Timeout: no i2c_done, err exactly 17 cycles after exec
    expect_txn(1'b1, 8'h05, 8'h7F, 1'b1);
    one_shot(1'b1, 7'h02, 9'h17F);
    wait_exec();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (req1_err | req1_done) break;
    end
    chk("timeout_latency", 32'(cnt), 17);
    chk("timeout_no_done", 32'(req1_done), 0);
    @(negedge clk);
    chk("timeout_idle", 32'(busy), 0);

    // i2c_done on the final timeout cycle: success wins
    expect_txn(1'b0, 8'h0E, 8'h0A, 1'b0);
    one_shot(1'b0, 7'h07, 9'h00A);
    wait_exec();
    pulse_done_after(16);
    @(negedge clk);
    chk("edge_done", 32'(req0_done), 1);
    chk("edge_no_err", 32'(req0_err), 0);

    // Reset in WAIT abandons the transaction silently
    expect_txn(1'b0, 8'h10, 8'h01, 1'b0);
    one_shot(1'b0, 7'h08, 9'h001);
    wait_exec();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exec_q.delete();
    resp_q.delete();
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_exec", 32'(i2c_exec), 0);
    chk("midrst_addr", 32'(i2c_addr), 0);
    chk("midrst_data", 32'(i2c_data_w), 0);
    chk("midrst_owner", 32'(owner), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_done_after(1);
    repeat (5) @(negedge clk);
    chk("postrst_idle", 32'(busy), 0);
    expect_txn(1'b1, 8'h1E, 8'h00, 1'b0);
    one_shot(1'b1, 7'h0F, 9'h000);
    wait_exec();
    pulse_done_after(2);
    @(negedge clk);
    chk("postrst_done", 32'(req1_done), 1);

    // Payload latched at grant; later valid drop and data change are ignored
    expect_txn(1'b0, 8'h0A, 8'h79, 1'b0);
    @(posedge clk);
    #1 req0_valid = 1'b1; req0_addr = 7'h05; req0_data = 9'h079;
    @(posedge clk);
    @(negedge clk);
    chk("latch_exec", 32'(i2c_exec), 1);
    @(posedge clk);
    #1 req0_valid = 1'b0; req0_addr = 7'h7F; req0_data = 9'h1FF;
    pulse_done_after(4);
    @(negedge clk);
    chk("latch_done", 32'(req0_done), 1);

    repeat (3) @(negedge clk);
    chk("exec_q_drained", 32'(exec_q.size()), 0);
    chk("resp_q_drained", 32'(resp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
